// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_queue
// Description : Instruction prefetch FIFO fed from a combinational imem, with
//               branch redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_queue #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       PC_W     = 64,
  parameter int unsigned       INST_W   = 32,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INST_W-1:0]          imem_data,
  input  logic                       br_taken,
  input  logic [PC_W-1:0]            br_target,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned       PTR_W    = $clog2(DEPTH);
  localparam int unsigned       CNT_W    = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [PC_W-1:0]   pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  always_comb begin
    pop        = (count_q != '0) & out_ready & ~br_taken;
    // A pop frees the head slot in the same cycle, so a full queue can still accept.
    push       = ~br_taken & ((count_q != FULL_CNT) | pop);
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (br_taken) begin
      fetch_pc_d = br_target;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + PC_W'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage needs no reset: unoccupied slots are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_data;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_inst  = inst_mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_queue
// Description : Randomized self-checking bench with a queue-based fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        br_taken;
  logic [63:0] br_target;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  fetch_prefetch_queue #(
    .DEPTH(DEPTH), .PC_W(64), .INST_W(32), .RESET_PC(64'h0)
  ) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .br_taken(br_taken), .br_target(br_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  assign imem_data = inst_of(imem_addr);

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      mq[$];
  logic [63:0] mpc;
  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue semantics of a fetch buffer.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mpc = 64'h0;
    end else if (br_taken) begin
      mq.delete();
      mpc = br_target;
    end else begin
      bit do_pop, do_push;
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = (mq.size() < DEPTH) || do_pop;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back('{pc: mpc, inst: inst_of(mpc)});
        mpc = mpc + 64'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && chk_en) begin
      chk("count", {61'd0, count}, 64'(mq.size()));
      chk("count_bound", {63'd0, (count <= 3'(DEPTH))}, 64'd1);
      chk("out_valid", {63'd0, out_valid}, {63'd0, (mq.size() != 0)});
      chk("imem_addr", imem_addr, mpc);
      if (mq.size() != 0) begin
        chk("out_pc", out_pc, mq[0].pc);
        chk("out_inst", {32'd0, out_inst}, {32'd0, mq[0].inst});
      end
    end
  end

  task automatic edge_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    br_taken  = 1'b0;
    br_target = 64'h0;
    out_ready = 1'b0;
    edge_cycles(2);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_count", {61'd0, count}, 64'd0);
    chk("rst_addr", imem_addr, 64'h0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Fill with no consumer
    edge_cycles(4);
    chk("fill_count", {61'd0, count}, 64'd4);
    chk("fill_addr", imem_addr, 64'd16);
    chk("fill_head_pc", out_pc, 64'd0);
    chk("fill_head_inst", {32'd0, out_inst}, {32'd0, inst_of(64'd0)});
    edge_cycles(1);
    chk("full_hold_addr", imem_addr, 64'd16);
    chk("full_hold_count", {61'd0, count}, 64'd4);

    // Simultaneous push/pop while full
    out_ready = 1'b1;
    edge_cycles(1);
    out_ready = 1'b0;
    chk("fullpp_count", {61'd0, count}, 64'd4);
    chk("fullpp_head", out_pc, 64'd4);
    chk("fullpp_addr", imem_addr, 64'd20);

    // Redirect while full
    br_taken  = 1'b1;
    br_target = 64'h100;
    out_ready = 1'b1;
    edge_cycles(1);
    br_taken  = 1'b0;
    out_ready = 1'b0;
    chk("redir_count", {61'd0, count}, 64'd0);
    chk("redir_valid", {63'd0, out_valid}, 64'd0);
    chk("redir_addr", imem_addr, 64'h100);
    edge_cycles(1);
    chk("redir_head", out_pc, 64'h100);
    chk("redir_count1", {61'd0, count}, 64'd1);

    // Back-to-back redirects keep the queue empty
    br_taken  = 1'b1;
    br_target = 64'h200;
    edge_cycles(1);
    br_target = 64'h300;
    edge_cycles(1);
    br_taken  = 1'b0;
    chk("dblredir_count", {61'd0, count}, 64'd0);
    chk("dblredir_addr", imem_addr, 64'h300);

    // Streaming from reset
    pulse_reset();
    out_ready = 1'b1;
    edge_cycles(1);
    for (int k = 1; k < 8; k++) begin
      edge_cycles(1);
      chk("stream_count", {61'd0, count}, 64'd1);
      chk("stream_pc", out_pc, 64'(4 * k));
    end

    // Randomized mixed traffic, including pointer wrap and redirects
    for (int i = 0; i < 400; i++) begin
      br_taken  = ($urandom_range(0, 19) == 0);
      br_target = {32'($urandom), 32'($urandom)};
      out_ready = ($urandom_range(0, 2) != 0);
      edge_cycles(1);
    end
    br_taken = 1'b0;

    // Asynchronous reset between edges with three entries queued
    pulse_reset();
    out_ready = 1'b0;
    edge_cycles(3);
    chk("pre_async_count", {61'd0, count}, 64'd3);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", {63'd0, out_valid}, 64'd0);
    chk("async_addr", imem_addr, 64'h0);
    chk("async_count", {61'd0, count}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 100; i++) begin
      br_taken  = ($urandom_range(0, 9) == 0);
      br_target = {32'($urandom), 30'($urandom), 2'b00};
      out_ready = $urandom_range(0, 1) == 1;
      edge_cycles(1);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
